// File: rtl/fe_pkg.sv
// Shared field definitions for GF(2^255-19) arithmetic: element type, modulus,
// multiplier latencies and the sequential multiplier's state encoding.
package fe_pkg;

    localparam int FE_W = 255;

    typedef logic [FE_W-1:0] fe_t;

    // p = 2^255 - 19 = 0x7fff...ffed
    localparam fe_t FE_P = {{250{1'b1}}, 5'b01101};

    localparam int FE_MUL_LAT2 = 255;
    localparam int FE_MUL_LAT4 = 128;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mul_state_e;

endpackage

// File: rtl/fe_addmod.sv
// Combinational modular addition (x + y) mod p for canonical inputs x, y < p.
// Since x + y < 2p, a single conditional subtract of p yields a canonical result.
module fe_addmod
    import fe_pkg::*;
(
    input  fe_t x_i,
    input  fe_t y_i,
    output fe_t s_o
);

    logic [FE_W:0] sum;
    logic [FE_W:0] diff;

    assign sum  = {1'b0, x_i} + {1'b0, y_i};
    assign diff = sum - {1'b0, FE_P};
    assign s_o  = (sum >= {1'b0, FE_P}) ? diff[FE_W-1:0] : sum[FE_W-1:0];

endmodule

// File: rtl/fe_mul_seq.sv
// Sequential MSB-first double-and-add multiplier over GF(2^255-19) with start/done handshake.
// Define FE_MUL_RADIX4_EN to consume two multiplier bits per cycle (128-cycle latency).
module fe_mul_seq
    import fe_pkg::*;
#(
    parameter int W = FE_W
)
(
    input  logic         clock,
    input  logic         resetn,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] out,
    output logic         busy
);

    if (W != FE_W || FE_MUL_LAT2 != FE_W || FE_MUL_LAT4 != (FE_W + 1) / 2) begin : g_bad_width
        $error("fe_mul_seq supports only W = 255");
    end

`ifdef FE_MUL_RADIX4_EN
    localparam int RBW      = FE_W + 1;
    localparam int CNT_INIT = FE_MUL_LAT4 - 1;
`else
    localparam int RBW      = FE_W;
    localparam int CNT_INIT = FE_MUL_LAT2 - 1;
`endif
    localparam int CW = $clog2(CNT_INIT + 1);

    mul_state_e     state_q, state_d;
    fe_t            ra_q, ra_d;
    logic [RBW-1:0] rb_q, rb_d;
    fe_t            acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    fe_t            out_q, out_d;
    logic           done_q, done_d;

    fe_t aRed;
    fe_t step;

    // a < 2^255 < 2p, so one subtract makes it canonical
    assign aRed = (a >= FE_P) ? (a - FE_P) : a;

`ifdef FE_MUL_RADIX4_EN
    fe_t  dbl0, sum0, mid, dbl1, sum1;
    logic bitHi, bitLo;

    assign bitHi = rb_q[{cnt_q, 1'b1}];
    assign bitLo = rb_q[{cnt_q, 1'b0}];

    fe_addmod u_dbl0 (.x_i(acc_q), .y_i(acc_q), .s_o(dbl0));
    fe_addmod u_add0 (.x_i(dbl0),  .y_i(ra_q),  .s_o(sum0));
    assign mid = bitHi ? sum0 : dbl0;

    fe_addmod u_dbl1 (.x_i(mid),   .y_i(mid),   .s_o(dbl1));
    fe_addmod u_add1 (.x_i(dbl1),  .y_i(ra_q),  .s_o(sum1));
    assign step = bitLo ? sum1 : dbl1;
`else
    fe_t  dbl0, sum0;
    logic bitCur;

    assign bitCur = rb_q[cnt_q];

    fe_addmod u_dbl0 (.x_i(acc_q), .y_i(acc_q), .s_o(dbl0));
    fe_addmod u_add0 (.x_i(dbl0),  .y_i(ra_q),  .s_o(sum0));
    assign step = bitCur ? sum0 : dbl0;
`endif

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ra_d    = aRed;
`ifdef FE_MUL_RADIX4_EN
                    rb_d    = {1'b0, b};
`else
                    rb_d    = b;
`endif
                    acc_d   = '0;
                    cnt_d   = CW'(CNT_INIT);
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = step;
                if (cnt_q == '0) begin
                    out_d   = step;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;
    assign out  = out_q;
    assign busy = (state_q == RUN);

endmodule

// File: tb/tb_fe_mul_seq.sv
// Scoreboard bench for fe_mul_seq: the driver queues a*b mod p from a wide-integer
// reference model, and a negedge monitor checks every done pulse, its latency and output hold.
module tb_fe_mul_seq;

    localparam logic [255:0] P = (256'd1 << 255) - 256'd19;
`ifdef FE_MUL_RADIX4_EN
    localparam int LAT = 128;
`else
    localparam int LAT = 255;
`endif

    logic         clock = 1'b0;
    logic         resetn;
    logic         start;
    logic [254:0] a;
    logic [254:0] b;
    logic         done;
    logic [254:0] out;
    logic         busy;

    typedef struct {
        logic [254:0] val;
        int           t0;
    } exp_t;

    exp_t         sb[$];
    int           testCount = 0;
    int           failCount = 0;
    int           edgeCnt   = 0;
    logic [254:0] heldOut   = '0;
    bit           monitorOn = 1'b0;

    fe_mul_seq dut (
        .clock (clock),
        .resetn(resetn),
        .start (start),
        .a     (a),
        .b     (b),
        .done  (done),
        .out   (out),
        .busy  (busy)
    );

    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        edgeCnt = edgeCnt + 1;
    end

    function automatic logic [254:0] refMul(input logic [254:0] x, input logic [254:0] y);
        logic [511:0] prod;
        logic [511:0] r;
        prod = {257'd0, x} * {257'd0, y};
        r    = prod % {256'd0, P};
        return r[254:0];
    endfunction

    function automatic logic [254:0] randFe();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r[254:0];
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        testCount = testCount + 1;
        if (actual !== expected) begin
            failCount = failCount + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, actual, expected, edgeCnt);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [254:0] x, input logic [254:0] y);
        exp_t e;
        a     = x;
        b     = y;
        start = 1'b1;
        cycle();
        start = 1'b0;
        e.val = refMul(x, y);
        e.t0  = edgeCnt;
        sb.push_back(e);
    endtask

    task automatic pulseIgnoredStart();
        a     = randFe();
        b     = randFe();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sb.size() != 0 && n < 600) begin
            cycle();
            n++;
        end
        if (sb.size() != 0) begin
            testCount = testCount + 1;
            failCount = failCount + 1;
            $display("[TB] FAIL drainTimeout: %0d results still pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: sampled on the falling edge, away from the DUT's active edge
    always @(negedge clock) begin
        if (monitorOn) begin
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    testCount = testCount + 1;
                    failCount = failCount + 1;
                    $display("[TB] FAIL unexpectedDone: done=1 with no pending request, expected done=0");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("product", out, e.val);
                    checkOutput("latency", edgeCnt, e.t0 + LAT);
                    checkOutput("busyAtDone", busy, 1'b0);
                    heldOut = e.val;
                end
            end else begin
                checkOutput("outHold", out, heldOut);
                checkOutput("busy", busy, sb.size() != 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [254:0] pv;
        logic [254:0] v;
        int           n;

        pv     = P[254:0];
        resetn = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        repeat (3) cycle();
        resetn = 1'b1;
        checkOutput("resetDone", done, 1'b0);
        checkOutput("resetBusy", busy, 1'b0);
        checkOutput("resetOut", out, 256'd0);
        monitorOn = 1'b1;

        applyStimulus(255'd7, 255'd7);
        waitDrain();

        v      = '0;
        v[128] = 1'b1;
        applyStimulus(v, v);
        waitDrain();

        applyStimulus(pv + 255'd1, 255'd5);
        waitDrain();

        applyStimulus(pv - 255'd1, pv - 255'd1);
        waitDrain();

        // Starts during a run must be ignored
        applyStimulus(255'd0, '1);
        repeat (40) cycle();
        pulseIgnoredStart();
        repeat (40) cycle();
        pulseIgnoredStart();
        waitDrain();

        // Abort at cycle 100: no done, state back to reset values
        applyStimulus(randFe(), randFe());
        repeat (99) cycle();
        resetn = 1'b0;
        cycle();
        resetn  = 1'b1;
        sb.delete();
        heldOut = '0;
        checkOutput("abortBusy", busy, 1'b0);
        checkOutput("abortOut", out, 256'd0);
        checkOutput("abortDone", done, 1'b0);
        repeat (300) cycle();

        v      = '0;
        v[254] = 1'b1;
        applyStimulus(255'd2, v);
        waitDrain();

        // Back-to-back: new start in the cycle done is high
        applyStimulus(randFe(), randFe());
        n = 0;
        while (done !== 1'b1 && n < 600) begin
            cycle();
            n++;
        end
        checkOutput("doneSeen", done, 1'b1);
        applyStimulus(255'd3, 255'd4);
        waitDrain();

        for (int i = 0; i < 6; i++) begin
            applyStimulus(randFe(), randFe());
            waitDrain();
        end

        repeat (5) cycle();
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
